// File: rtl/lcd_pkg.sv
// lcd_pkg
// Shared types and constants for the 4-bit HD44780-style LCD write controller:
// controller and strobe state enums, wait-select codes, the power-on init ROM
// (nibble phase and byte phase), command constants and small helpers.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT_NIB,
        ST_INIT_BYTE,
        ST_IDLE,
        ST_SEND_HI,
        ST_GAP,
        ST_SEND_LO,
        ST_EXEC_WAIT
    } lcd_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SETUP,
        TX_PULSE,
        TX_HOLD
    } tx_state_e;

    typedef enum logic [1:0] {
        WAIT_INIT1,
        WAIT_INIT2,
        WAIT_EXEC,
        WAIT_LONG
    } wait_sel_e;

    typedef struct packed {
        logic [3:0] nib;
        wait_sel_e  wsel;
    } init_nib_t;

    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_HOME       = 8'h02;
    localparam logic [7:0] CMD_FUNC_SET   = 8'h28;
    localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
    localparam logic [7:0] CMD_DISP_ON    = 8'h0C;

    localparam logic [3:0] NIB_WAKE = 4'h3;
    localparam logic [3:0] NIB_4BIT = 4'h2;

    // Wake-up nibbles sent while the panel is still in 8-bit mode.
    function automatic init_nib_t init_nib_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return '{nib: NIB_WAKE, wsel: WAIT_INIT1};
            2'd1:    return '{nib: NIB_WAKE, wsel: WAIT_INIT2};
            2'd2:    return '{nib: NIB_WAKE, wsel: WAIT_EXEC};
            default: return '{nib: NIB_4BIT, wsel: WAIT_EXEC};
        endcase
    endfunction

    // Full-byte configuration sequence once the bus is in 4-bit mode.
    function automatic logic [7:0] init_byte_rom(input logic [1:0] idx);
        case (idx)
            2'd0:    return CMD_FUNC_SET;
            2'd1:    return CMD_ENTRY_MODE;
            2'd2:    return CMD_DISP_ON;
            default: return CMD_CLEAR;
        endcase
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx
// Strobes one nibble onto the LCD bus: SETUP (1 cycle, e=0, rs/db driven),
// PULSE (T_EH cycles, e=1), HOLD (1 cycle, e=0, rs/db unchanged).
// rs/db keep their last value while idle.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_start             begin a strobe (accepted only when o_idle)
//   i_nibble, i_rs      nibble and register select, latched on i_start
//   o_idle              strobe engine free
//   o_done              high during the HOLD cycle
//   o_lcd_e/rs/db       registered LCD bus
//
// state    | meaning
// TX_IDLE  | waiting for i_start, bus holds last values
// TX_SETUP | rs/db valid, e low
// TX_PULSE | e high for T_EH cycles
// TX_HOLD  | e low, rs/db held, o_done high
module lcd_nibble_tx
    import lcd_pkg::*;
#(
    parameter int T_EH  = 12,
    parameter int CNT_W = 4
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [3:0] i_nibble,
    input  logic       i_rs,
    output logic       o_idle,
    output logic       o_done,
    output logic       o_lcd_e,
    output logic       o_lcd_rs,
    output logic [3:0] o_lcd_db
);

    tx_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_e;
    logic             r_rs;
    logic [3:0]       r_db;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= TX_IDLE;
            r_cnt   <= '0;
            r_e     <= 1'b0;
            r_rs    <= 1'b0;
            r_db    <= 4'h0;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (i_start) begin
                        r_db    <= i_nibble;
                        r_rs    <= i_rs;
                        r_state <= TX_SETUP;
                    end
                end
                TX_SETUP: begin
                    r_e     <= 1'b1;
                    r_cnt   <= CNT_W'(T_EH - 1);
                    r_state <= TX_PULSE;
                end
                TX_PULSE: begin
                    if (r_cnt == '0) begin
                        r_e     <= 1'b0;
                        r_state <= TX_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign o_idle   = (r_state == TX_IDLE);
    assign o_done   = (r_state == TX_HOLD);
    assign o_lcd_e  = r_e;
    assign o_lcd_rs = r_rs;
    assign o_lcd_db = r_db;

endmodule

// File: rtl/lcd_ctrl_4bit.sv
// lcd_ctrl_4bit
// Write-only 4-bit LCD controller: runs the power-on wait and init sequence,
// then sends one byte (command or data) per accepted request as two nibble
// strobes separated by T_GAP idle cycles, followed by a T_EXEC or T_LONG
// (clear/home) execution wait.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   req_valid/req_ready                 request handshake
//   req_rs, req_data, req_hex           request payload (rs=1 data, 0 command)
//   init_done                           init sequence finished (sticky)
//   busy                                controller not in IDLE
//   sf_e, lcd_e, lcd_rs, lcd_rw, lcd_db LCD bus (sf_e=1, lcd_rw=0 constant)
// Build option:
//   LCD_HEX_EN  when defined, req_hex=1 sends the ASCII hex digit of
//               req_data[3:0] as data (rs forced to 1); otherwise req_hex
//               is ignored.
//
// state        | meaning
// ST_PWR_WAIT  | power-on delay T_PWR
// ST_INIT_NIB  | wake-up nibbles 3,3,3,2 each followed by its own wait
// ST_INIT_BYTE | load next init command into the byte sender
// ST_IDLE      | ready for a request
// ST_SEND_HI   | strobe high nibble
// ST_GAP       | T_GAP cycles between nibbles
// ST_SEND_LO   | strobe low nibble
// ST_EXEC_WAIT | post-byte execution wait, then IDLE or next init byte
module lcd_ctrl_4bit
    import lcd_pkg::*;
#(
    parameter int T_PWR   = 750000,
    parameter int T_INIT1 = 205000,
    parameter int T_INIT2 = 5000,
    parameter int T_EH    = 12,
    parameter int T_GAP   = 50,
    parameter int T_EXEC  = 2000,
    parameter int T_LONG  = 82000
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    input  logic       req_hex,
    output logic       req_ready,
    output logic       init_done,
    output logic       busy,
    output logic       sf_e,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [3:0] lcd_db
);

    localparam int T_MAX = max_int(max_int(max_int(T_PWR, T_INIT1), max_int(T_INIT2, T_EH)),
                                   max_int(max_int(T_GAP, T_EXEC), max_int(T_LONG, 2)));
    localparam int CNT_W = $clog2(T_MAX);

    lcd_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic             r_wait;
    logic [7:0]       r_byte;
    logic             r_rs;
    logic             r_init_done;

    logic             w_tx_start;
    logic [3:0]       w_tx_nib;
    logic             w_tx_rs;
    logic             w_tx_idle;
    logic             w_tx_done;
    logic             w_long;
    logic [7:0]       w_req_byte;
    logic             w_req_rs;
    init_nib_t        w_init_nib;

`ifdef LCD_HEX_EN
    assign w_req_byte = req_hex ? hex_ascii(req_data[3:0]) : req_data;
    assign w_req_rs   = req_hex ? 1'b1 : req_rs;
`else
    logic w_unused_hex;
    assign w_unused_hex = req_hex;
    assign w_req_byte   = req_data;
    assign w_req_rs     = req_rs;
`endif

    function automatic logic [CNT_W-1:0] wait_load(input wait_sel_e sel);
        case (sel)
            WAIT_INIT1: return CNT_W'(T_INIT1 - 1);
            WAIT_INIT2: return CNT_W'(T_INIT2 - 1);
            WAIT_LONG:  return CNT_W'(T_LONG - 1);
            default:    return CNT_W'(T_EXEC - 1);
        endcase
    endfunction

    assign w_init_nib = init_nib_rom(r_idx);
    assign w_long     = !r_rs && ((r_byte == CMD_CLEAR) || (r_byte == CMD_HOME));

    // The low-nibble strobe is launched in the last GAP cycle so that its
    // SETUP cycle directly follows the T_GAP idle cycles.
    always_comb begin
        w_tx_start = 1'b0;
        w_tx_nib   = r_byte[3:0];
        w_tx_rs    = r_rs;
        case (r_state)
            ST_INIT_NIB: begin
                w_tx_start = !r_wait && w_tx_idle;
                w_tx_nib   = w_init_nib.nib;
                w_tx_rs    = 1'b0;
            end
            ST_SEND_HI: begin
                w_tx_start = w_tx_idle;
                w_tx_nib   = r_byte[7:4];
            end
            ST_GAP: begin
                w_tx_start = (r_cnt == '0);
            end
            default: begin
                w_tx_start = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_PWR_WAIT;
            r_cnt       <= '0;
            r_idx       <= 2'd0;
            r_wait      <= 1'b0;
            r_byte      <= 8'h00;
            r_rs        <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_PWR_WAIT: begin
                    // Counter comes out of reset cleared; r_wait marks it loaded.
                    if (!r_wait) begin
                        r_cnt  <= CNT_W'(T_PWR - 1);
                        r_wait <= 1'b1;
                    end else if (r_cnt == '0) begin
                        r_wait  <= 1'b0;
                        r_idx   <= 2'd0;
                        r_state <= ST_INIT_NIB;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_INIT_NIB: begin
                    if (!r_wait) begin
                        if (w_tx_done) begin
                            r_wait <= 1'b1;
                            r_cnt  <= wait_load(w_init_nib.wsel);
                        end
                    end else if (r_cnt == '0) begin
                        r_wait <= 1'b0;
                        if (r_idx == 2'd3) begin
                            r_idx   <= 2'd0;
                            r_state <= ST_INIT_BYTE;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_INIT_BYTE: begin
                    r_byte  <= init_byte_rom(r_idx);
                    r_rs    <= 1'b0;
                    r_state <= ST_SEND_HI;
                end
                ST_IDLE: begin
                    if (req_valid && r_init_done) begin
                        r_byte  <= w_req_byte;
                        r_rs    <= w_req_rs;
                        r_state <= ST_SEND_HI;
                    end
                end
                ST_SEND_HI: begin
                    if (w_tx_done) begin
                        r_cnt   <= CNT_W'(T_GAP - 1);
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_SEND_LO;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_SEND_LO: begin
                    if (w_tx_done) begin
                        r_cnt   <= wait_load(w_long ? WAIT_LONG : WAIT_EXEC);
                        r_state <= ST_EXEC_WAIT;
                    end
                end
                ST_EXEC_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_init_done) begin
                        r_state <= ST_IDLE;
                    end else if (r_idx == 2'd3) begin
                        r_idx       <= 2'd0;
                        r_init_done <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_idx   <= r_idx + 2'd1;
                        r_state <= ST_INIT_BYTE;
                    end
                end
                default: begin
                    r_state <= ST_PWR_WAIT;
                end
            endcase
        end
    end

    lcd_nibble_tx #(
        .T_EH  (T_EH),
        .CNT_W (CNT_W)
    ) u_nibble_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_tx_start),
        .i_nibble (w_tx_nib),
        .i_rs     (w_tx_rs),
        .o_idle   (w_tx_idle),
        .o_done   (w_tx_done),
        .o_lcd_e  (lcd_e),
        .o_lcd_rs (lcd_rs),
        .o_lcd_db (lcd_db)
    );

    assign req_ready = (r_state == ST_IDLE) && r_init_done;
    assign init_done = r_init_done;
    assign busy      = (r_state != ST_IDLE);
    assign sf_e      = 1'b1;
    assign lcd_rw    = 1'b0;

endmodule
